// File: rtl/riscv_trace_pkg.sv
// State encoding and entry sizing for the retirement trace buffer.
// TRACE_WDATA_EN widens each entry with the writeback enable and data.
package riscv_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  function automatic int entry_w(int xlen);
`ifdef TRACE_WDATA_EN
    return 2 * xlen + 33;
`else
    return xlen + 32;
`endif
  endfunction

endpackage

// File: rtl/riscv_trace_buffer_if.sv
// Readout stream of the trace buffer: valid/ready plus the entry fields.
interface riscv_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_instr;
  logic            rd_we;
  logic [XLEN-1:0] rd_wdata;
  logic            rd_last;

  modport master (output rd_valid, rd_pc, rd_instr, rd_we, rd_wdata, rd_last,
                  input  rd_ready);
  modport slave  (input  rd_valid, rd_pc, rd_instr, rd_we, rd_wdata, rd_last,
                  output rd_ready);
endinterface

// File: rtl/riscv_trace_buffer_trace_ram.sv
// DEPTH x W flop array: one synchronous write port, one asynchronous read port, no reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/riscv_trace_buffer.sv
// Circular retirement-trace buffer: capture until trigger + POST_TRIG, then stream oldest-first.
// Build with TRACE_WDATA_EN to also record cap_we/cap_wdata in each entry.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                   clk,
  input  logic                   start,
  input  logic                   arm,
  input  logic                   clear,
  input  logic                   cap_valid,
  input  logic [XLEN-1:0]        cap_pc,
  input  logic [31:0]            cap_instr,
  input  logic                   cap_we,
  input  logic [XLEN-1:0]        cap_wdata,
  input  logic                   trig_pc_en,
  input  logic [XLEN-1:0]        trig_pc,
  input  logic                   trig_force,
  riscv_trace_buffer_if.master   rd,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(XLEN);

  trace_state_t  st_q, st_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] post_q, post_d;
  logic          hit, cap_en, rd_fire;
  logic [EW-1:0] wentry, rentry;

  assign hit     = cap_valid & (trig_force | (trig_pc_en & (cap_pc == trig_pc)));
  assign cap_en  = cap_valid & ~clear & ((st_q == ARMED) | (st_q == POST));
  // Oldest entry sits count slots behind the write pointer; reads walk it forward.
  assign rptr    = wptr_q - cnt_q[AW-1:0];
  assign rd.rd_valid = (st_q == DONE) & (cnt_q != '0);
  assign rd_fire = rd.rd_valid & rd.rd_ready;

  always_comb begin
    st_d   = st_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    post_d = post_q;
    if (clear) begin
      st_d   = IDLE;
      wptr_d = '0;
      cnt_d  = '0;
      post_d = '0;
    end else begin
      case (st_q)
        IDLE: if (arm) begin
          st_d   = ARMED;
          wptr_d = '0;
          cnt_d  = '0;
        end
        ARMED, POST: if (cap_valid) begin
          wptr_d = wptr_q + AW'(1);
          if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
          if (st_q == ARMED) begin
            if (hit) begin
              st_d   = (POST_TRIG == 0) ? DONE : POST;
              post_d = AW'(POST_TRIG);
            end
          end else begin
            post_d = post_q - AW'(1);
            if (post_q == AW'(1)) st_d = DONE;
          end
        end
        DONE: if (rd_fire) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) st_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge start)
    if (!start) begin
      st_q   <= IDLE;
      wptr_q <= '0;
      cnt_q  <= '0;
      post_q <= '0;
    end else begin
      st_q   <= st_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      post_q <= post_d;
    end

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (cap_en),
    .waddr (wptr_q),
    .wdata (wentry),
    .raddr (rptr),
    .rdata (rentry)
  );

  assign rd.rd_pc    = rd.rd_valid ? rentry[XLEN-1:0]       : '0;
  assign rd.rd_instr = rd.rd_valid ? rentry[XLEN+31:XLEN]   : '0;
  assign rd.rd_last  = rd.rd_valid & (cnt_q == CW'(1));

`ifdef TRACE_WDATA_EN
  assign wentry      = {cap_wdata, cap_we, cap_instr, cap_pc};
  assign rd.rd_we    = rd.rd_valid & rentry[XLEN+32];
  assign rd.rd_wdata = rd.rd_valid ? rentry[2*XLEN+32:XLEN+33] : '0;
`else
  logic unused_wd;
  assign unused_wd   = ^{cap_we, cap_wdata};
  assign wentry      = {cap_instr, cap_pc};
  assign rd.rd_we    = 1'b0;
  assign rd.rd_wdata = '0;
`endif

  assign state = st_q;
  assign count = cnt_q;
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed + random bench for riscv_trace_buffer against a queue-based reference model.
module tb_riscv_trace_buffer;
  localparam int XLEN = 32, DEPTH = 16, POST_TRIG = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [31:0] wdata;
  } ent_t;

  logic        clk = 1'b0;
  logic        start, arm, clear, cap_valid, cap_we, trig_pc_en, trig_force;
  logic [31:0] cap_pc, cap_instr, cap_wdata, trig_pc;
  logic [1:0]  state;
  logic [4:0]  count;

  int   n_cmp = 0, n_err = 0;
  int   ms, mpost;
  ent_t mq[$];
  int   nrd;
  logic [31:0] last_pc;

  riscv_trace_buffer_if #(.XLEN(XLEN)) rd_if();

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .start(start), .arm(arm), .clear(clear),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_we(cap_we), .cap_wdata(cap_wdata),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .trig_force(trig_force),
    .rd(rd_if), .state(state), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, required summary before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; mpost = 0; mq.delete();
  endtask

  // Behaviour at one rising edge, from the current inputs.
  task automatic model_edge();
    bit hit;
    if (!start) begin model_reset(); return; end
    hit = cap_valid && (trig_force || (trig_pc_en && cap_pc == trig_pc));
    if (clear) begin ms = 0; mq.delete(); end
    else case (ms)
      0: if (arm) begin ms = 1; mq.delete(); end
      1, 2: if (cap_valid) begin
        mq.push_back('{cap_pc, cap_instr, cap_we, cap_wdata});
        if (mq.size() > DEPTH) mq.delete(0);
        if (ms == 1) begin
          if (hit) begin mpost = POST_TRIG; ms = (POST_TRIG == 0) ? 3 : 2; end
        end else begin
          mpost--;
          if (mpost == 0) ms = 3;
        end
      end
      3: if (mq.size() > 0 && rd_if.rd_ready) begin
        mq.delete(0);
        if (mq.size() == 0) ms = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string ph);
    bit   v;
    ent_t e;
    v = (ms == 3) && (mq.size() > 0);
    e = '{32'h0, 32'h0, 1'b0, 32'h0};
    if (v) e = mq[0];
`ifndef TRACE_WDATA_EN
    e.we = 1'b0; e.wdata = 32'h0;
`endif
    chk({ph, ".state"},    64'(state),           64'(ms));
    chk({ph, ".count"},    64'(count),           64'(mq.size()));
    chk({ph, ".rd_valid"}, 64'(rd_if.rd_valid),  64'(v));
    chk({ph, ".rd_last"},  64'(rd_if.rd_last),   64'(v && mq.size() == 1));
    chk({ph, ".rd_pc"},    64'(rd_if.rd_pc),     64'(e.pc));
    chk({ph, ".rd_instr"}, 64'(rd_if.rd_instr),  64'(e.instr));
    chk({ph, ".rd_we"},    64'(rd_if.rd_we),     64'(e.we));
    chk({ph, ".rd_wdata"}, 64'(rd_if.rd_wdata),  64'(e.wdata));
  endtask

  task automatic step(input string ph);
    model_edge();
    @(posedge clk); #1;
    check_all(ph);
  endtask

  task automatic idle_in();
    arm = 1'b0; clear = 1'b0; cap_valid = 1'b0; cap_we = 1'b0;
    trig_pc_en = 1'b0; trig_force = 1'b0; rd_if.rd_ready = 1'b0;
    cap_pc = 32'h0; cap_instr = 32'h0; cap_wdata = 32'h0; trig_pc = 32'h0;
  endtask

  // mode 0: ready held, 1: ready 1,0,0 repeating, 2: random ready
  task automatic readout(input string ph, input int mode);
    logic [31:0] prev_pc;
    bit          stalled;
    nrd = 0; last_pc = 32'h0; stalled = 1'b0; prev_pc = 32'h0;
    for (int i = 0; i < 200 && ms == 3; i++) begin
      case (mode)
        0:       rd_if.rd_ready = 1'b1;
        1:       rd_if.rd_ready = (i % 3 == 0);
        default: rd_if.rd_ready = 1'($urandom % 2);
      endcase
      cap_valid = 1'($urandom % 2); cap_pc = $urandom; trig_force = 1'($urandom % 2);
      if (stalled) chk({ph, ".stall_pc"}, 64'(rd_if.rd_pc), 64'(prev_pc));
      if (rd_if.rd_valid && rd_if.rd_ready) nrd++;
      if (rd_if.rd_valid && rd_if.rd_ready && rd_if.rd_last) last_pc = rd_if.rd_pc;
      stalled = rd_if.rd_valid && !rd_if.rd_ready;
      prev_pc = rd_if.rd_pc;
      step(ph);
    end
    rd_if.rd_ready = 1'b0; cap_valid = 1'b0; trig_force = 1'b0;
  endtask

  initial begin
    idle_in(); start = 1'b0; model_reset();
    #1;
    // Held in reset with capture activity and arm requests
    for (int i = 0; i < 6; i++) begin
      cap_valid = i[0]; arm = 1'b1; cap_pc = $urandom;
      step("rst");
    end
    arm = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cap_valid = 1'b1; cap_pc = $urandom; step("noarm");
    end
    chk("noarm.count0", 64'(count), 64'(0));

    // Basic window: trigger at PC 0x40, the 17th retirement
    cap_valid = 1'b0; arm = 1'b1; step("arm"); arm = 1'b0;
    trig_pc_en = 1'b1; trig_pc = 32'h40;
    for (int i = 0; i < 25; i++) begin
      cap_valid = 1'b1; cap_pc = 32'(i * 4); cap_instr = $urandom;
      cap_we = 1'($urandom % 2); cap_wdata = $urandom;
      step("win");
    end
    cap_valid = 1'b0; trig_pc_en = 1'b0;
    chk("win.state_done", 64'(state),        64'(3));
    chk("win.count_full", 64'(count),        64'(DEPTH));
    chk("win.first_pc",   64'(rd_if.rd_pc),  64'h24);
    readout("win_rd", 0);
    chk("win.nread",   64'(nrd),     64'(DEPTH));
    chk("win.last_pc", 64'(last_pc), 64'h60);
    chk("win.idle",    64'(state),   64'(0));

    // Under-fill with forced trigger, random capture gaps, backpressured readout
    arm = 1'b1; step("arm2"); arm = 1'b0;
    for (int j = 0; j < 100 && ms != 3; j++) begin
      cap_valid = (j == 0) ? 1'b1 : 1'($urandom % 2);
      trig_force = (j == 0) ? 1'b1 : 1'($urandom % 4 == 0);
      cap_pc = $urandom; cap_instr = $urandom; cap_we = 1'($urandom % 2); cap_wdata = $urandom;
      step("uf");
    end
    cap_valid = 1'b0; trig_force = 1'b0;
    chk("uf.state_done", 64'(state), 64'(3));
    chk("uf.count",      64'(count), 64'(POST_TRIG + 1));
    readout("uf_rd", 1);
    chk("uf.nread", 64'(nrd),   64'(POST_TRIG + 1));
    chk("uf.idle",  64'(state), 64'(0));

    // clear wins over a same-cycle trigger and arm
    arm = 1'b1; step("arm3"); arm = 1'b0;
    for (int i = 0; i < 3; i++) begin cap_valid = 1'b1; cap_pc = $urandom; step("clr_fill"); end
    cap_valid = 1'b1; trig_force = 1'b1; clear = 1'b1; arm = 1'b1; step("clr");
    chk("clr.state", 64'(state), 64'(0));
    chk("clr.count", 64'(count), 64'(0));
    clear = 1'b0; arm = 1'b0; cap_valid = 1'b0; trig_force = 1'b0;

    // arm during POST is ignored; writeback fields carried through
    arm = 1'b1; step("arm4"); arm = 1'b0;
    cap_valid = 1'b1; trig_force = 1'b1; cap_we = 1'b1; cap_wdata = 32'hDEADBEEF;
    cap_pc = 32'h100; step("post_trig");
    trig_force = 1'b0; cap_valid = 1'b0; arm = 1'b1; step("post_arm");
    chk("post_arm.state", 64'(state), 64'(2));
    arm = 1'b0;
    for (int i = 0; i < POST_TRIG; i++) begin
      cap_valid = 1'b1; cap_pc = 32'h104 + 32'(4 * i); cap_instr = $urandom; step("post_fill");
    end
    cap_valid = 1'b0; cap_we = 1'b0; cap_wdata = 32'h0;
    chk("mac.state", 64'(state), 64'(3));
`ifdef TRACE_WDATA_EN
    chk("mac.rd_we",    64'(rd_if.rd_we),    64'(1));
    chk("mac.rd_wdata", 64'(rd_if.rd_wdata), 64'hDEADBEEF);
`else
    chk("mac.rd_we",    64'(rd_if.rd_we),    64'(0));
    chk("mac.rd_wdata", 64'(rd_if.rd_wdata), 64'(0));
`endif
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("part_rd");
    rd_if.rd_ready = 1'b0;
    // Asynchronous reset in the middle of readout
    start = 1'b0; #1;
    model_reset();
    chk("async.state",    64'(state),          64'(0));
    chk("async.count",    64'(count),          64'(0));
    chk("async.rd_valid", 64'(rd_if.rd_valid), 64'(0));
    check_all("async");
    step("async_hold");
    start = 1'b1;

    // Random traffic on all controls
    for (int i = 0; i < 1500; i++) begin
      start      = ($urandom % 400 == 0) ? 1'b0 : 1'b1;
      arm        = 1'($urandom % 8 == 0);
      clear      = 1'($urandom % 150 == 0);
      cap_valid  = 1'($urandom % 4 != 0);
      cap_pc     = 32'($urandom_range(0, 31)) << 2;
      cap_instr  = $urandom;
      cap_we     = 1'($urandom % 2);
      cap_wdata  = $urandom;
      trig_pc_en = 1'($urandom % 2);
      trig_pc    = 32'h20;
      trig_force = 1'($urandom % 100 == 0);
      rd_if.rd_ready = 1'($urandom % 2);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Parametrised retirement-trace capture buffer for the RISC-V cores. It attaches to the retire/writeback signals of any core generation, from the single-cycle CPU to later multi-cycle variants. It holds a circular history of the last `DEPTH` retired instructions, stops on a PC-match or forced trigger after `POST_TRIG` further retirements, then streams the frozen window out oldest-first over a valid/ready port. It replaces wire-level probing of the CPU from the bench with a synthesisable, width- and depth-generic observer.

## Interface
- `XLEN`, 32, data/PC width
- `DEPTH`, 16, trace entries; power of two, ≥2
- `POST_TRIG`, 8, entries captured after the trigger entry; 0 ≤ `POST_TRIG` < `DEPTH`
- `clk`  in  1  system clock; all state updates on the rising edge
- `start`  in  1  asynchronous active-low reset: 0 holds the block in reset, 1 runs
- `arm`  in  1  IDLE→ARMED request
- `clear`  in  1  synchronous abort to IDLE from any state; count cleared
- `cap_valid`  in  1  one retired instruction this cycle
- `cap_pc`  in  XLEN  PC of retired instruction
- `cap_instr`  in  32  instruction word
- `cap_we`  in  1  register-file write enable of the instruction
- `cap_wdata`  in  XLEN  register writeback data
- `trig_pc_en`  in  1  enable PC-match trigger
- `trig_pc`  in  XLEN  trigger PC
- `trig_force`  in  1  immediate trigger, qualified by `cap_valid`
- `rd_ready`  in  1  consumer accepts the current entry
- `rd_valid`  out  1  entry available
- `rd_pc`  out  XLEN, `rd_instr`  out  32, `rd_we`  out  1, `rd_wdata`  out  XLEN: entry fields
- `rd_last`  out  1  current entry is the newest one
- `state`  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- `count`  out  $clog2(DEPTH)+1  valid entries held

## Operation
- Reset: `state`=IDLE; pointers, `count` and the post counter are 0. All outputs are 0. Storage contents are don't-care.
- IDLE: capture is ignored. `arm`=1 → ARMED, with wptr=0 and count=0.
- ARMED: each `cap_valid` writes entry[wptr]; wptr increments mod `DEPTH`; `count` saturates at `DEPTH`, and the oldest entry is overwritten once full.
- Trigger: `cap_valid` AND (`trig_force` OR (`trig_pc_en` AND `cap_pc`==`trig_pc`)). The triggering entry is written, then the state goes to POST with postcnt=`POST_TRIG`, or straight to DONE if `POST_TRIG`=0.
- POST: each `cap_valid` writes as in ARMED and decrements postcnt. The write that takes postcnt to 0 moves the state to DONE. Further triggers are ignored.
- DONE: capture is ignored. rptr = (wptr − count) mod `DEPTH`, so the oldest entry is read first. `rd_valid`=1 while count>0. A handshake (`rd_valid`&`rd_ready`) increments rptr and decrements count. `rd_last`=(count==1). The handshake on the last entry → IDLE.
- `arm` outside IDLE is ignored. `clear` wins over every other input, including `arm` and a same-cycle trigger.
- `rd_*` fields are 0 whenever `rd_valid`=0.

## Timing
- Capture is zero-bubble: one entry per cycle at full `cap_valid` rate, written on the same edge.
- Trigger latency: `state` shows POST/DONE the cycle after the triggering edge.
- The read path is an asynchronous read of the flop array: `rd_*` is valid in the same cycle as `rd_valid`, and a new entry appears the cycle after each handshake. Sustained throughput is 1 entry/cycle with `rd_ready` held high.
- `rd_valid` must not depend combinationally on `rd_ready`.
- Reset mid-operation, whether during POST or readout: the block returns to IDLE asynchronously, and any partial trace is lost.

## Configuration
- `TRACE_WDATA_EN` defined: `cap_we` and `cap_wdata` are stored, and `rd_we`/`rd_wdata` carry them.
- Not defined: those fields are not stored, the entry is `XLEN`+32 bits wide, and `rd_we`/`rd_wdata` are tied to 0. Ports remain present.

## Structure
- Package `riscv_trace_pkg`: state encoding constants (IDLE/ARMED/POST/DONE) and the entry-width function of `XLEN`, honouring `TRACE_WDATA_EN`.
- One sub-module, `trace_ram`: a `DEPTH`×entry flop array with one synchronous write port, one asynchronous read port and no reset.
- The FSM, pointers, counters and trigger compare sit in the top level.

## Test plan
- Reset/idle: hold `start`=0 with `cap_valid` toggling → `state`=0, `count`=0, `rd_valid`=0. Release `start` without `arm` → count stays 0.
- Basic window, `DEPTH`=16, `POST_TRIG`=8: arm, then retire PCs 0x0,0x4,… with trigger at 0x40 (17th entry) → DONE after PC 0x60. Readout yields 16 entries, 0x24…0x60, with `rd_last` on 0x60.
- Under-fill: arm, retire 3 instructions with `trig_force` on the 1st and `POST_TRIG`=2 → count=3, readout 3 entries, then IDLE.
- Backpressure: in DONE toggle `rd_ready` 1,0,0,1… → no entry is skipped or duplicated, and `rd_*` stays stable while stalled.
- Simultaneous events: `clear` and a trigger in the same cycle → IDLE, count=0. `arm` during POST → ignored. Reset during readout → IDLE immediately.
- Macro: without `TRACE_WDATA_EN`, retire with `cap_we`=1, `cap_wdata`=0xDEADBEEF → `rd_we`=0 and `rd_wdata`=0. With it defined → the values are returned.
